// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock display.
// Latency: AN/SEG/DP change on the prescaler tick edge and already show the new slot; FRAME is a 1-cycle pulse after the frame-wrap edge.
// Backpressure: none; free-running scan, digit inputs are sampled once per frame.
//
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   d_*_i                 BCD digits (sec/min/hour, ones/tens) from the timekeeper
//   blank_lz_i            blank hour-tens when it is zero
//   colon_en_i            enable the blinking colon (DP on slots 2 and 4)
//   an_o, seg_o, dp_o     active-low anode enables, segments {g..a}, decimal point
//   frame_o               one-cycle pulse at the start of every scan frame
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] d_sec_one_i,
    input  logic [3:0] d_sec_ten_i,
    input  logic [3:0] d_min_one_i,
    input  logic [3:0] d_min_ten_i,
    input  logic [3:0] d_hour_one_i,
    input  logic [3:0] d_hour_ten_i,
    input  logic       blank_lz_i,
    input  logic       colon_en_i,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       frame_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST = 3'd5;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][3:0] sh_q, sh_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            phase_q, phase_d;
    logic            lit_q, lit_d;
    logic [5:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    logic       tick;
    logic       wrap;
    logic [3:0] digit;

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        wrap    = tick && (idx_q == IDX_LAST);

        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        lit_d   = lit_q | wrap;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        frame_d = wrap;
        digit   = 4'd0;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        if (wrap) begin
            sh_d = {d_hour_ten_i, d_hour_one_i, d_min_ten_i,
                    d_min_one_i, d_sec_ten_i, d_sec_one_i};
        end

        // The wrap that leaves the reset/idle state opens the first frame
        // without closing one, so only later wraps count toward the blink.
        if (wrap && lit_q) begin
            if (fcnt_q == FRM_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + FW'(1);
            end
        end

        // Outputs are built from next-state index and shadow so the new slot
        // appears on the tick edge itself rather than one slot late.
        case (idx_d)
            3'd0:    digit = sh_d[0];
            3'd1:    digit = sh_d[1];
            3'd2:    digit = sh_d[2];
            3'd3:    digit = sh_d[3];
            3'd4:    digit = sh_d[4];
            default: digit = sh_d[5];
        endcase

        if (tick) begin
            an_d = ~(6'b000001 << idx_d);
            if ((idx_d == IDX_LAST) && blank_lz_i && (digit == 4'd0)) begin
                seg_d = 7'b1111111;
            end else begin
                seg_d = seg_decode(digit);
            end
            dp_d = ~(((idx_d == 3'd2) || (idx_d == 3'd4)) && colon_en_i && phase_d);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= IDX_LAST;
            sh_q    <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            lit_q   <= 1'b0;
            an_q    <= 6'b111111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            lit_q   <= lit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Outputs are sampled 1 ns after each rising edge; inputs are driven at the same point.
// One task per feature, each with its own inline comparisons.
module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] d_so, d_st, d_mo, d_mt, d_ho, d_ht;
    logic       blank_lz;
    logic       colon_en;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int checks   = 0;
    int failures = 0;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .d_sec_one_i  (d_so),
        .d_sec_ten_i  (d_st),
        .d_min_one_i  (d_mo),
        .d_min_ten_i  (d_mt),
        .d_hour_one_i (d_ho),
        .d_hour_ten_i (d_ht),
        .blank_lz_i   (blank_lz),
        .colon_en_i   (colon_en),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .frame_o      (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] ht, ho, mt, mo, st, so);
        d_ht = ht; d_ho = ho; d_mt = mt; d_mo = mo; d_st = st; d_so = so;
    endtask

    // Reset, release, and advance to the first lit slot (slot 0 of frame 1).
    task automatic start_frame();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++; if (an !== 6'b111111) begin failures++; $display("FAIL reset_an got=%b exp=111111", an); end
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [6];
        logic [5:0] exp_an;
        exp_seg = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blank_lz = 1'b0;
        colon_en = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++; if (an !== 6'b111111 || frame !== 1'b0) begin
                failures++; $display("FAIL pre_tick cycle=%0d an=%b frame=%b exp an=111111 frame=0", i, an, frame);
            end
        end
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            exp_an = ~(6'b000001 << k);
            checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an slot=%0d got=%b exp=%b", k, an, exp_an); end
            checks++; if (seg !== exp_seg[k]) begin failures++; $display("FAIL scan_seg slot=%0d got=%b exp=%b", k, seg, exp_seg[k]); end
            checks++; if (frame !== (k == 0)) begin failures++; $display("FAIL scan_frame slot=%0d got=%b exp=%b", k, frame, (k == 0)); end
            checks++; if (dp !== 1'b1) begin failures++; $display("FAIL scan_dp slot=%0d got=%b exp=1", k, dp); end
            cyc(1);
            checks++; if (frame !== 1'b0) begin failures++; $display("FAIL scan_frame_low slot=%0d got=%b exp=0", k, frame); end
            cyc(3);
        end
        checks++; if (frame !== 1'b1 || an !== 6'b111110) begin
            failures++; $display("FAIL scan_frame2 frame=%b an=%b exp frame=1 an=111110", frame, an);
        end
    endtask

    task automatic test_shadow();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        start_frame();
        d_mo = 4'd7;
        cyc(8);
        checks++; if (an !== 6'b111011 || seg !== 7'b0011001) begin
            failures++; $display("FAIL shadow_old an=%b seg=%b exp an=111011 seg=0011001", an, seg);
        end
        cyc(24);
        checks++; if (an !== 6'b111011 || seg !== 7'b1111000) begin
            failures++; $display("FAIL shadow_new an=%b seg=%b exp an=111011 seg=1111000", an, seg);
        end
    endtask

    task automatic test_blank();
        set_digits(4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blank_lz = 1'b1;
        start_frame();
        cyc(20);
        checks++; if (an !== 6'b011111 || seg !== 7'b1111111) begin
            failures++; $display("FAIL blank_on an=%b seg=%b exp an=011111 seg=1111111", an, seg);
        end
        blank_lz = 1'b0;
        cyc(24);
        checks++; if (an !== 6'b011111 || seg !== 7'b1000000) begin
            failures++; $display("FAIL blank_off an=%b seg=%b exp an=011111 seg=1000000", an, seg);
        end
    endtask

    task automatic test_colon();
        logic exp_dp;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        colon_en = 1'b1;
        start_frame();
        for (int f = 1; f <= 5; f++) begin
            for (int s = 0; s < 6; s++) begin
                exp_dp = !(((s == 2) || (s == 4)) && ((f == 3) || (f == 4)));
                checks++; if (dp !== exp_dp) begin
                    failures++; $display("FAIL colon_dp frame=%0d slot=%0d got=%b exp=%b", f, s, dp, exp_dp);
                end
                cyc(4);
            end
        end
        colon_en = 1'b0;
        cyc(24);
        for (int s = 0; s < 6; s++) begin
            checks++; if (dp !== 1'b1) begin failures++; $display("FAIL colon_off slot=%0d got=%b exp=1", s, dp); end
            cyc(4);
        end
    endtask

    task automatic test_code11();
        set_digits(4'd1, 4'd2, 4'd11, 4'd4, 4'd5, 4'd11);
        start_frame();
        checks++; if (an !== 6'b111110 || seg !== 7'b1111111) begin
            failures++; $display("FAIL code11_slot0 an=%b seg=%b exp an=111110 seg=1111111", an, seg);
        end
        cyc(12);
        checks++; if (an !== 6'b110111 || seg !== 7'b1111111) begin
            failures++; $display("FAIL code11_slot3 an=%b seg=%b exp an=110111 seg=1111111", an, seg);
        end
        cyc(4);
        checks++; if (seg !== 7'b0100100) begin failures++; $display("FAIL code11_slot4 got=%b exp=0100100", seg); end
    endtask

    task automatic test_decode();
        logic [6:0] e1 [6];
        logic [6:0] e2 [6];
        e1 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
        e2 = '{7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111};
        set_digits(4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0);
        start_frame();
        set_digits(4'd15, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6);
        for (int s = 0; s < 6; s++) begin
            checks++; if (seg !== e1[s]) begin failures++; $display("FAIL decode_a slot=%0d got=%b exp=%b", s, seg, e1[s]); end
            cyc(4);
        end
        for (int s = 0; s < 6; s++) begin
            checks++; if (seg !== e2[s]) begin failures++; $display("FAIL decode_b slot=%0d got=%b exp=%b", s, seg, e2[s]); end
            cyc(4);
        end
    endtask

    task automatic test_midreset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        start_frame();
        cyc(12);
        checks++; if (an !== 6'b110111) begin failures++; $display("FAIL midrst_pre got=%b exp=110111", an); end
        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1 || frame !== 1'b0) begin
            failures++; $display("FAIL midrst_async an=%b seg=%b dp=%b frame=%b exp 111111/1111111/1/0", an, seg, dp, frame);
        end
        rst = 1'b0;
        cyc(3);
        checks++; if (an !== 6'b111111 || frame !== 1'b0) begin
            failures++; $display("FAIL midrst_idle an=%b frame=%b exp an=111111 frame=0", an, frame);
        end
        cyc(1);
        checks++; if (frame !== 1'b1 || an !== 6'b111110 || seg !== 7'b0000010) begin
            failures++; $display("FAIL midrst_first frame=%b an=%b seg=%b exp 1/111110/0000010", frame, an, seg);
        end
    endtask

    initial begin
        rst = 1'b1;
        blank_lz = 1'b0;
        colon_en = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_scan();
        test_shadow();
        test_blank();
        blank_lz = 1'b0;
        test_colon();
        colon_en = 1'b0;
        test_code11();
        test_decode();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
